// File: rtl/pool_pkg.sv
// Shared FSM encoding and counter sizing helper for the max-pooling stage.
package pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_max_stream_if.sv
// Control, input stream and pooled output stream of the max-pooling stage.
interface pool_max_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         start_pool;
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         busy;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] data_output;
  logic                         end_pool;

  modport master (
    output start_pool, in_valid, data_in,
    input  busy, out_valid, data_output, end_pool
  );

  modport slave (
    input  start_pool, in_valid, data_in,
    output busy, out_valid, data_output, end_pool
  );
endinterface

// File: rtl/pool_line_buf.sv
// One partial maximum per output column; unreset storage, read combinationally.
module pool_line_buf #(
  parameter int DEPTH      = 13,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 4
) (
  input  logic                  clk1,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk1) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/pool_max_stream.sv
// Streaming non-overlapping POOL x POOL max pooling over a raster-ordered,
// channel-after-channel input stream, using one line of column partials.
module pool_max_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FM_SIZE    = 27,
  parameter int POOL       = 2,
  parameter int CH         = 8
) (
  input logic              clk1,
  input logic              rst_n,
  pool_max_stream_if.slave bus
);
  localparam int OUT_SIZE = (FM_SIZE - POOL) / POOL + 1;
  localparam int EDGE     = OUT_SIZE * POOL;
  localparam int CW       = cnt_w(FM_SIZE);
  localparam int PW       = cnt_w(POOL);
  localparam int HW       = cnt_w(CH);

  localparam logic [CW-1:0] FM_LAST = CW'(FM_SIZE - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(POOL - 1);
  localparam logic [HW-1:0] CH_LAST = HW'(CH - 1);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  pool_state_e   state_q;
  logic [CW-1:0] col_q, row_q, oc_q;
  logic [PW-1:0] wc_q, wr_q;
  logic [HW-1:0] ch_q;
  sample_t       rmax_q;
  logic          busy_q, out_valid_q, end_pool_q;
  sample_t       data_output_q;

  logic          beat_s, in_win_s, col_end_s, row_end_s, last_beat_s, lb_we_s;
  logic [CW-1:0] lb_raddr_s;
  sample_t       m_s, win_s, lb_wdata_s;
  logic [DATA_WIDTH-1:0] lb_rdata_s;

  assign beat_s      = (state_q == ST_RUN) && bus.in_valid;
  assign in_win_s    = (int'(col_q) < EDGE) && (int'(row_q) < EDGE);
  assign col_end_s   = (wc_q == P_LAST);
  assign row_end_s   = (wr_q == P_LAST);
  assign last_beat_s = (col_q == FM_LAST) && (row_q == FM_LAST) && (ch_q == CH_LAST);

  // Horizontal max within the window row, then fold into the column partial.
  assign m_s        = (wc_q == {PW{1'b0}}) ? bus.data_in : smax(rmax_q, bus.data_in);
  assign win_s      = smax(sample_t'(lb_rdata_s), m_s);
  assign lb_wdata_s = (wr_q == {PW{1'b0}}) ? m_s : win_s;
  assign lb_we_s    = beat_s && in_win_s && col_end_s;
  assign lb_raddr_s = in_win_s ? oc_q : {CW{1'b0}};

  pool_line_buf #(
    .DEPTH      (OUT_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (CW)
  ) u_line_buf (
    .clk1  (clk1),
    .we    (lb_we_s),
    .waddr (oc_q),
    .wdata (lb_wdata_s),
    .raddr (lb_raddr_s),
    .rdata (lb_rdata_s)
  );

  // FSM, raster counters, row max and registered outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      col_q         <= {CW{1'b0}};
      row_q         <= {CW{1'b0}};
      oc_q          <= {CW{1'b0}};
      wc_q          <= {PW{1'b0}};
      wr_q          <= {PW{1'b0}};
      ch_q          <= {HW{1'b0}};
      rmax_q        <= {DATA_WIDTH{1'b0}};
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      end_pool_q    <= 1'b0;
      data_output_q <= {DATA_WIDTH{1'b0}};
    end else begin
      out_valid_q <= 1'b0;
      end_pool_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_pool) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            col_q   <= {CW{1'b0}};
            row_q   <= {CW{1'b0}};
            oc_q    <= {CW{1'b0}};
            wc_q    <= {PW{1'b0}};
            wr_q    <= {PW{1'b0}};
            ch_q    <= {HW{1'b0}};
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (beat_s) begin
            rmax_q <= m_s;
            if (in_win_s && col_end_s && row_end_s) begin
              out_valid_q   <= 1'b1;
              data_output_q <= win_s;
            end
            // Column wrap restarts the window phase; a row wrap moves to the next map.
            if (col_q == FM_LAST) begin
              col_q <= {CW{1'b0}};
              oc_q  <= {CW{1'b0}};
              wc_q  <= {PW{1'b0}};
              if (row_q == FM_LAST) begin
                row_q <= {CW{1'b0}};
                wr_q  <= {PW{1'b0}};
                ch_q  <= ch_q + 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
                wr_q  <= row_end_s ? {PW{1'b0}} : wr_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
              wc_q  <= col_end_s ? {PW{1'b0}} : wc_q + 1'b1;
              oc_q  <= col_end_s ? oc_q + 1'b1 : oc_q;
            end
            if (last_beat_s) begin
              state_q    <= ST_DONE;
              end_pool_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.data_output = data_output_q;
  assign bus.end_pool    = end_pool_q;
endmodule

// File: tb/tb_pool_max_stream.sv
// Scoreboard bench: three pooling instances (4x4/1ch, 5x5/1ch, 4x4/3ch) share one input stream.
module tb_pool_max_stream;
  logic clk1 = 1'b0;
  logic rst_n;
  logic in_valid;
  logic signed [31:0] data_in;
  logic [2:0] start_v;
  int sel;

  int n_checks = 0;
  int n_fail = 0;
  int ep_cnt = 0;
  int busy_drop = 0;
  int stray = 0;
  bit busy_watch = 1'b0;
  logic signed [31:0] exp_q[$];

  always #5 clk1 = ~clk1;

  pool_max_stream_if #(.DATA_WIDTH(32)) if_a ();
  pool_max_stream_if #(.DATA_WIDTH(32)) if_b ();
  pool_max_stream_if #(.DATA_WIDTH(32)) if_c ();

  assign if_a.start_pool = start_v[0];
  assign if_b.start_pool = start_v[1];
  assign if_c.start_pool = start_v[2];
  assign if_a.in_valid = in_valid;
  assign if_b.in_valid = in_valid;
  assign if_c.in_valid = in_valid;
  assign if_a.data_in = data_in;
  assign if_b.data_in = data_in;
  assign if_c.data_in = data_in;

  pool_max_stream #(.DATA_WIDTH(32), .FM_SIZE(4), .POOL(2), .CH(1)) u_dut_a (
    .clk1(clk1), .rst_n(rst_n), .bus(if_a));
  pool_max_stream #(.DATA_WIDTH(32), .FM_SIZE(5), .POOL(2), .CH(1)) u_dut_b (
    .clk1(clk1), .rst_n(rst_n), .bus(if_b));
  pool_max_stream #(.DATA_WIDTH(32), .FM_SIZE(4), .POOL(2), .CH(3)) u_dut_c (
    .clk1(clk1), .rst_n(rst_n), .bus(if_c));

  logic [2:0] ov_v, ep_v, bz_v;
  logic ov_sel, ep_sel, bz_sel;
  logic signed [31:0] dout_sel;

  assign ov_v = {if_c.out_valid, if_b.out_valid, if_a.out_valid};
  assign ep_v = {if_c.end_pool, if_b.end_pool, if_a.end_pool};
  assign bz_v = {if_c.busy, if_b.busy, if_a.busy};

  always_comb begin
    ov_sel = ov_v[sel];
    ep_sel = ep_v[sel];
    bz_sel = bz_v[sel];
    case (sel)
      1: dout_sel = if_b.data_output;
      2: dout_sel = if_c.data_output;
      default: dout_sel = if_a.data_output;
    endcase
  end

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every pooled output of the selected instance.
  always @(negedge clk1) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (k != sel && (ov_v[k] || ep_v[k])) stray++;
      end
      if (ov_sel) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", dout_sel, 32'sd0 - 32'sd1);
          if (dout_sel == -32'sd1) check_val("unexpected_out_flag", 32'sd1, 32'sd0);
        end else begin
          check_val("pool_out", dout_sel, exp_q.pop_front());
        end
      end
      if (ep_sel) ep_cnt++;
      if (busy_watch && !bz_sel) busy_drop++;
    end
  end

  function automatic logic signed [31:0] max4(input logic signed [31:0] a, b, c, d);
    logic signed [31:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Drives one layer, pushing the window max as each completing beat is driven.
  task automatic run_layer(input int s, input int fm, input int nch, input int offs,
                           input int max_gap, input int repulse_at, input int stop_after,
                           input bit last_out);
    logic signed [31:0] img [0:4][0:4];
    logic signed [31:0] v;
    int n;
    int edge_sz;
    n = 0;
    edge_sz = ((fm - 2) / 2 + 1) * 2;
    sel = s;
    ep_cnt = 0;
    busy_drop = 0;
    @(negedge clk1);
    start_v[s] = 1'b1;
    @(negedge clk1);
    start_v = 3'b000;
    busy_watch = 1'b1;
    for (int ch = 0; ch < nch; ch++) begin
      for (int r = 0; r < fm; r++) begin
        for (int c = 0; c < fm; c++) begin
          repeat ($urandom_range(max_gap, 0)) @(negedge clk1);
          v = ch * 100 + r * fm + c + offs;
          img[r][c] = v;
          if ((c % 2 == 1) && (r % 2 == 1) && (c < edge_sz) && (r < edge_sz))
            exp_q.push_back(max4(img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c]));
          in_valid = 1'b1;
          data_in = v;
          if (n == repulse_at) start_v[s] = 1'b1;
          @(negedge clk1);
          in_valid = 1'b0;
          start_v = 3'b000;
          n++;
          if (n == stop_after) begin
            busy_watch = 1'b0;
            return;
          end
        end
      end
    end
    busy_watch = 1'b0;
    check_val("end_pool_at_done", ep_sel, 1);
    check_val("out_valid_at_done", ov_sel, last_out);
    @(negedge clk1);
    check_val("end_pool_single_cycle", ep_sel, 0);
    check_val("busy_idle_after", bz_sel, 0);
    check_val("end_pool_count", ep_cnt, 1);
    check_val("busy_held", busy_drop, 0);
    check_val("queue_drained", exp_q.size(), 0);
    check_val("no_stray_outputs", stray, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    data_in = 32'sd0;
    start_v = 3'b000;
    sel = 0;
    repeat (2) @(negedge clk1);
    check_val("reset_out_valid", {29'd0, ov_v}, 0);
    check_val("reset_end_pool", {29'd0, ep_v}, 0);
    check_val("reset_busy", {29'd0, bz_v}, 0);
    check_val("reset_dout_a", if_a.data_output, 0);
    rst_n = 1'b1;
    @(negedge clk1);

    // 4x4 raster 0..15, continuous
    run_layer(0, 4, 1, 0, 0, -1, -1, 1'b1);
    // signed values -8..7
    run_layer(0, 4, 1, -8, 0, -1, -1, 1'b1);
    // 5x5 with dropped edge column/row
    run_layer(1, 5, 1, 0, 0, -1, -1, 1'b0);
    // three channels with random gaps
    run_layer(2, 4, 3, 0, 3, -1, -1, 1'b1);

    // reset after 9 beats
    run_layer(0, 4, 1, 0, 0, -1, 9, 1'b0);
    check_val("pre_reset_dout", dout_sel, 7);
    check_val("pre_reset_busy", bz_sel, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_reset_out_valid", ov_sel, 0);
    check_val("mid_reset_dout", dout_sel, 0);
    check_val("mid_reset_busy", bz_sel, 0);
    check_val("mid_reset_end_pool", ep_sel, 0);
    check_val("mid_reset_queue", exp_q.size(), 0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    run_layer(0, 4, 1, 0, 0, -1, -1, 1'b1);

    // beats while idle, then a layer with start_pool re-pulsed mid-stream
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      data_in = 32'sd999;
      @(negedge clk1);
    end
    in_valid = 1'b0;
    @(negedge clk1);
    check_val("idle_beats_busy", bz_sel, 0);
    run_layer(0, 4, 1, 0, 1, 6, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
